gf_mul: RTL and testbench



---
 rtl/gf_mul_if.sv | 20 ++
 rtl/gf_mul.sv | 100 ++++++++++
 tb/tb_gf_mul.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gf_mul_if.sv
// rtl/gf_mul_if.sv - start/operand/result bundle for the GF(2^8) multiplier
// Optional busy signal present when GF_MUL_BUSY_EN is defined.
interface gf_mul_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] in_1;
  logic [WIDTH-1:0] in_2;
  logic [WIDTH-1:0] out;
  logic             done;
`ifdef GF_MUL_BUSY_EN
  logic             busy;

  modport master (output start, output in_1, output in_2, input out, input done, input busy);
  modport slave  (input start, input in_1, input in_2, output out, output done, output busy);
`else
  modport master (output start, output in_1, output in_2, input out, input done);
  modport slave  (input start, input in_1, input in_2, output out, output done);
`endif
endinterface

// File: rtl/gf_mul.sv
// rtl/gf_mul.sv - bit-serial MSB-first GF(2^8) multiplier, reduction by 0x100|POLY
// Optional busy output enabled by defining GF_MUL_BUSY_EN.
module gf_mul #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = 8'h1B
) (
  input  logic   clk,
  input  logic   rst_n,
  gf_mul_if.slave bus
);

  localparam int IW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] out_q;
  logic             done_q;
  logic [IW-1:0]    idx;
  logic             b_bit;
`ifdef GF_MUL_BUSY_EN
  logic             busy_q;
`endif

  function automatic logic [WIDTH-1:0] xtime(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? POLY : '0);
  endfunction

  // idx starts one above the MSB: that leading step multiplies a zero bit into
  // an all-zero accumulator, giving the 9-cycle start-to-done latency for free.
  always_comb begin
    b_bit    = 1'b0;
    if (idx < IW'(WIDTH)) begin
      b_bit = b_reg[idx[IW-2:0]];
    end
    acc_next = xtime(acc) ^ (b_bit ? a_reg : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      acc    <= '0;
      idx    <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
`ifdef GF_MUL_BUSY_EN
      busy_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_reg  <= bus.in_1;
            b_reg  <= bus.in_2;
            acc    <= '0;
            idx    <= IW'(WIDTH);
            state  <= RUN;
`ifdef GF_MUL_BUSY_EN
            busy_q <= 1'b1;
`endif
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= acc_next;
          if (idx == '0) begin
            out_q  <= acc_next;
            done_q <= 1'b1;
            state  <= DONE;
`ifdef GF_MUL_BUSY_EN
            busy_q <= 1'b0;
`endif
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out  = out_q;
  assign bus.done = done_q;
`ifdef GF_MUL_BUSY_EN
  assign bus.busy = busy_q;
`endif

endmodule

// File: tb/tb_gf_mul.sv
// tb/tb_gf_mul.sv - self-checking bench for gf_mul against an LSB-first peasant-multiply model
// Busy checks compiled in when GF_MUL_BUSY_EN is defined.
module tb_gf_mul;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  gf_mul_if bus ();

  gf_mul dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gf_ref(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = x;
    bb = y;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Called at posedge+1; returns at the sample where done is seen (or after timeout).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit hold,
                        output int lat, output int busy_cnt, output bit busy_at_done);
    lat          = -1;
    busy_cnt     = 0;
    busy_at_done = 1'b0;
    bus.start = 1'b1;
    bus.in_1  = a;
    bus.in_2  = b;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    for (int n = 0; n <= 20; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
`ifdef GF_MUL_BUSY_EN
      if (bus.busy === 1'b1) busy_cnt++;
      busy_at_done = bus.busy;
`endif
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.in_1  = 8'h00;
    bus.in_2  = 8'h00;
    repeat (10) @(posedge clk);
    #1;
    tests++;
    if (bus.out !== 8'h00) begin fails++; $display("FAIL reset_out got %h want 00", bus.out); end
    tests++;
    if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done); end
`ifdef GF_MUL_BUSY_EN
    tests++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_first_product();
    int lat, bc;
    bit bd;
    run_op(8'hE9, 8'h05, 1'b0, lat, bc, bd);
    tests++;
    if (lat !== 9) begin fails++; $display("FAIL first_latency got %0d want 9", lat); end
    tests++;
    if (bus.out !== 8'h60) begin fails++; $display("FAIL first_out got %h want 60", bus.out); end
`ifdef GF_MUL_BUSY_EN
    tests++;
    if (bc !== 9 || bd !== 1'b0) begin
      fails++; $display("FAIL first_busy got cnt=%0d at_done=%b want cnt=9 at_done=0", bc, bd);
    end
`endif
    repeat (3) begin
      @(posedge clk);
      #1;
      tests++;
      if (bus.done !== 1'b0 || bus.out !== 8'h60) begin
        fails++; $display("FAIL first_hold got done=%b out=%h want done=0 out=60", bus.done, bus.out);
      end
    end
  endtask

  task automatic test_products();
    logic [7:0] ta [5] = '{8'h02, 8'h53, 8'h01, 8'h00, 8'hCA};
    logic [7:0] tb [5] = '{8'h80, 8'hCA, 8'hA7, 8'hFF, 8'h53};
    logic [7:0] te [5] = '{8'h1B, 8'h01, 8'hA7, 8'h00, 8'h01};
    int lat, bc;
    bit bd;
    for (int t = 0; t < 5; t++) begin
      run_op(ta[t], tb[t], 1'b0, lat, bc, bd);
      tests++;
      if (lat !== 9 || bus.out !== te[t]) begin
        fails++;
        $display("FAIL product_%h_%h got lat=%0d out=%h want lat=9 out=%h", ta[t], tb[t], lat, bus.out, te[t]);
      end
      @(posedge clk);
      #1;
      tests++;
      if (bus.done !== 1'b0) begin fails++; $display("FAIL product_single_pulse got done=%b want 0", bus.done); end
    end
  endtask

  task automatic test_ignore_start();
    int dones;
    int lat;
    logic [7:0] seen;
    dones = 0;
    lat   = -1;
    seen  = 8'hXX;
    bus.start = 1'b1;
    bus.in_1  = 8'hE9;
    bus.in_2  = 8'h05;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (n == 3) begin
        bus.start = 1'b1;
        bus.in_1  = 8'hFF;
        bus.in_2  = 8'hFF;
      end else if (n == 4) begin
        bus.start = 1'b0;
      end
      if (bus.done === 1'b1) begin
        dones++;
        if (lat < 0) begin
          lat  = n;
          seen = bus.out;
        end
      end
    end
    tests++;
    if (dones !== 1 || lat !== 9 || seen !== 8'h60) begin
      fails++;
      $display("FAIL ignore_start got dones=%0d lat=%0d out=%h want dones=1 lat=9 out=60", dones, lat, seen);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, bc;
    bit bd;
    run_op(8'hE9, 8'h05, 1'b1, lat1, bc, bd);
    tests++;
    if (lat1 !== 9 || bus.out !== 8'h60) begin
      fails++; $display("FAIL b2b_first got lat=%0d out=%h want lat=9 out=60", lat1, bus.out);
    end
    run_op(8'h02, 8'h80, 1'b0, lat2, bc, bd);
    tests++;
    if (lat2 !== 9 || bus.out !== 8'h1B) begin
      fails++; $display("FAIL b2b_second got lat=%0d out=%h want lat=9 out=1B", lat2, bus.out);
    end
`ifdef GF_MUL_BUSY_EN
    tests++;
    if (bc !== 9 || bd !== 1'b0) begin
      fails++; $display("FAIL b2b_busy got cnt=%0d at_done=%b want cnt=9 at_done=0", bc, bd);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [7:0] a, b, exp;
    int lat, bc;
    bit bd;
    for (int t = 0; t < 16; t++) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      exp = gf_ref(a, b);
      run_op(a, b, 1'b0, lat, bc, bd);
      tests++;
      if (lat !== 9 || bus.out !== exp) begin
        fails++;
        $display("FAIL random_%h_%h got lat=%0d out=%h want lat=9 out=%h", a, b, lat, bus.out, exp);
      end
`ifdef GF_MUL_BUSY_EN
      tests++;
      if (bc !== 9 || bd !== 1'b0) begin
        fails++; $display("FAIL random_busy got cnt=%0d at_done=%b want cnt=9 at_done=0", bc, bd);
      end
`endif
      if (t[0]) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset_midop();
    int dones;
    bus.start = 1'b1;
    bus.in_1  = 8'h53;
    bus.in_2  = 8'hCA;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.out !== 8'h00 || bus.done !== 1'b0) begin
      fails++; $display("FAIL midop_reset got out=%h done=%b want out=00 done=0", bus.out, bus.done);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dones = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) dones++;
    end
    tests++;
    if (dones !== 0 || bus.out !== 8'h00) begin
      fails++; $display("FAIL midop_no_done got dones=%0d out=%h want dones=0 out=00", dones, bus.out);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_first_product();
    test_products();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
